// File: rtl/spi_slave_rx_if.sv
// Bundles the SPI pins and the rx/tx word handshakes of the SPI mode-0 responder.
interface spi_slave_rx_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              dc;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] rx_data;
  logic              rx_dc;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              overrun;
  logic              frame_err;

  modport slave (
    input  sclk, cs, mosi, dc, rx_ready, tx_data, tx_valid,
    output miso, miso_oe, rx_data, rx_dc, rx_valid, tx_ready, overrun, frame_err
  );

  modport master (
    output sclk, cs, mosi, dc, rx_ready, tx_data, tx_valid,
    input  miso, miso_oe, rx_data, rx_dc, rx_valid, tx_ready, overrun, frame_err
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder: oversamples the pins on clk, deserialises MSB-first words
// tagged with dc, and shifts a response word out on miso while cs is low.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  spi_slave_rx_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, dc_sync;
  logic sclk_p0, cs_p0, mosi_p0, dc_p0;
  logic sclk_d, cs_d;
  logic rise_p1, fall_p1, cs_fall_p1, cs_rise_p1;
  logic mosi_p1, dc_p1;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr, tx_sr;
  logic              word_dc;
  logic              miso_oe, rx_valid, rx_dc, overrun, frame_err;
  logic [DATA_W-1:0] rx_data;

  logic word_done, take_rise, take_fall, accept;

  assign sclk_p0 = sclk_sync[SYNC_STAGES-1];
  assign cs_p0   = cs_sync[SYNC_STAGES-1];
  assign mosi_p0 = mosi_sync[SYNC_STAGES-1];
  assign dc_p0   = dc_sync[SYNC_STAGES-1];

  // p0: pin synchronisers and edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      dc_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], bus.dc};
      sclk_d    <= sclk_p0;
      cs_d      <= cs_p0;
    end
  end

  // p1: registered edge strobes, with mosi/dc delayed to stay aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_p1    <= 1'b0;
      fall_p1    <= 1'b0;
      cs_fall_p1 <= 1'b0;
      cs_rise_p1 <= 1'b0;
    end else begin
      rise_p1    <= sclk_p0 & ~sclk_d;
      fall_p1    <= ~sclk_p0 & sclk_d;
      cs_fall_p1 <= ~cs_p0 & cs_d;
      cs_rise_p1 <= cs_p0 & ~cs_d;
    end
  end

  always_ff @(posedge clk) begin
    mosi_p1 <= mosi_p0;
    dc_p1   <= dc_p0;
  end

  // A fall with bit_cnt = 0 is the trailing edge of the previous word; shifting
  // there would discard the MSB that LOAD just placed on miso.
  assign word_done = (state == SHIFT) && (bit_cnt == CNT_LAST);
  assign take_rise = (state == SHIFT) && !word_done && !cs_rise_p1 && rise_p1;
  assign take_fall = (state == SHIFT) && !word_done && !cs_rise_p1 && !rise_p1
                     && fall_p1 && (bit_cnt != '0);
  assign accept    = !rx_valid || bus.rx_ready;

  always_ff @(posedge clk) begin
    if (state == LOAD)
      tx_sr <= bus.tx_valid ? bus.tx_data : '0;
    else if (take_fall)
      tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
    if (take_rise) begin
      rx_sr <= {rx_sr[DATA_W-2:0], mosi_p1};
      if (bit_cnt == CNT_PEN)
        word_dc <= dc_p1;
    end
  end

  // p2: framing FSM and holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      miso_oe   <= 1'b0;
      rx_data   <= '0;
      rx_dc     <= 1'b0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      miso_oe   <= ~cs_p0;
      if (rx_valid && bus.rx_ready)
        rx_valid <= 1'b0;
      case (state)
        IDLE: if (cs_fall_p1) state <= LOAD;
        LOAD: begin
          bit_cnt <= '0;
          state   <= cs_rise_p1 ? IDLE : SHIFT;
        end
        SHIFT: begin
          if (word_done) begin
            if (accept) begin
              rx_data  <= rx_sr;
              rx_dc    <= word_dc;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= cs_rise_p1 ? IDLE : LOAD;
          end else if (cs_rise_p1) begin
            frame_err <= (bit_cnt != '0);
            bit_cnt   <= '0;
            state     <= IDLE;
          end else if (take_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.miso      = miso_oe & tx_sr[DATA_W-1];
  assign bus.miso_oe   = miso_oe;
  assign bus.rx_data   = rx_data;
  assign bus.rx_dc     = rx_dc;
  assign bus.rx_valid  = rx_valid;
  assign bus.tx_ready  = (state == LOAD) && bus.tx_valid;
  assign bus.overrun   = overrun;
  assign bus.frame_err = frame_err;
endmodule
